// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory port of the fetch stage.
//   memReq  : fetch request, driven by the fetch unit
//   memAddr : word-aligned fetch address, driven by the fetch unit
//   memRdy  : memory completes the pending request this cycle
//   memData : instruction word, valid when memReq && memRdy
// master = fetch unit side, slave = instruction memory side.
interface fetch_pc_unit_if;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memRdy;
  logic [15:0] memData;

  modport master (output memReq, output memAddr, input memRdy, input memData);
  modport slave  (input memReq, input memAddr, output memRdy, output memData);
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage of the 16-bit datapath.
// Holds the fetch address, requests instruction words over the memory
// handshake and buffers one fetched instruction together with its PC.
// Ports:
//   i_clk, i_rst   : clock and synchronous active-high reset
//   i_en           : fetch enable, 0 stops issuing new requests
//   i_stall        : decode not ready, buffered instruction must hold
//   i_pcSrc        : redirect, load i_target as the next fetch address
//   i_target       : redirect address from the branch/jump mux (bit 0 ignored)
//   mem            : instruction-memory handshake (master side)
//   o_pc           : address of the instruction held in o_ir
//   o_pcPlus2      : o_pc + 2, wrapping (link value)
//   o_ir           : buffered instruction
//   o_irValid      : o_ir holds an instruction not yet consumed by decode
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] INC      = 16'd2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_stall,
  input  logic                   i_pcSrc,
  input  logic [15:0]            i_target,
  fetch_pc_unit_if.master        mem,
  output logic [15:0]            o_pc,
  output logic [15:0]            o_pcPlus2,
  output logic [15:0]            o_ir,
  output logic                   o_irValid
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_fa;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_irValid;
  logic        w_memReq;
  logic        w_capture;
  logic [15:0] w_targetAligned;

  // Redirect targets are forced onto a halfword boundary.
  assign w_targetAligned = i_target & 16'hFFFE;
  assign w_capture       = w_memReq && mem.memRdy;

  // State register: the only thing the FSM remembers is whether we fetch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: fetching simply follows the enable, redirects included.
  // A request acknowledged in the cycle En drops is still captured below.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_en)  w_nextState = FETCH;
      FETCH:   if (!i_en) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Request only when the buffer has room (empty, or being consumed now)
  // and no redirect is discarding this cycle's address.
  always_comb begin
    w_memReq = 1'b0;
    if (r_state == FETCH) begin
      w_memReq = !i_pcSrc && (!r_irValid || !i_stall);
    end
  end

  // Datapath: redirect beats capture beats consume. A redirect leaves IR
  // and PC untouched; only the valid flag tells decode they are stale.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fa      <= RESET_PC;
      r_pc      <= RESET_PC;
      r_ir      <= 16'h0000;
      r_irValid <= 1'b0;
    end else if (i_pcSrc) begin
      r_fa      <= w_targetAligned;
      r_irValid <= 1'b0;
    end else if (w_capture) begin
      r_ir      <= mem.memData;
      r_pc      <= r_fa;
      r_irValid <= 1'b1;
      r_fa      <= r_fa + INC;
    end else if (r_irValid && !i_stall) begin
      r_irValid <= 1'b0;
    end
  end

  assign mem.memReq  = w_memReq;
  assign mem.memAddr = r_fa;
  assign o_pc        = r_pc;
  assign o_pcPlus2   = r_pc + 16'd2;
  assign o_ir        = r_ir;
  assign o_irValid   = r_irValid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] KEY      = 16'hA5A5;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        pcSrc;
  logic [15:0] target;
  logic [15:0] pc;
  logic [15:0] pcPlus2;
  logic [15:0] ir;
  logic        irValid;

  fetch_pc_unit_if memIf ();

  fetch_pc_unit #(.RESET_PC(RESET_PC), .INC(16'd2)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_stall   (stall),
    .i_pcSrc   (pcSrc),
    .i_target  (target),
    .mem       (memIf.master),
    .o_pc      (pc),
    .o_pcPlus2 (pcPlus2),
    .o_ir      (ir),
    .o_irValid (irValid)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun   = 0;
  int testsFailed = 0;

  // Reference model of the fetch stage, expressed as the architectural
  // facts a reader of the specification would track.
  bit          mKnown   = 0;
  bit          mFetching;
  logic [15:0] mFa;
  logic [15:0] mPc;
  logic [15:0] mIr;
  bit          mValid;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, answer from instruction memory, check the
  // combinational request, advance the model and check registered outputs.
  task automatic applyStimulus(input bit iRst, input bit iEn, input bit iStall,
                               input bit iPcSrc, input logic [15:0] iTarget,
                               input bit iRdy);
    bit expReq;
    bit ack;
    @(negedge clk);
    rst          = iRst;
    en           = iEn;
    stall        = iStall;
    pcSrc        = iPcSrc;
    target       = iTarget;
    memIf.memRdy = iRdy;
    #1;
    memIf.memData = memIf.memAddr ^ KEY;
    #1;
    expReq = mKnown && mFetching && !iPcSrc && (!mValid || !iStall);
    if (mKnown && !iRst) begin
      checkOutput("memReq", {15'd0, memIf.memReq}, {15'd0, expReq});
      checkOutput("memAddrPre", memIf.memAddr, mFa);
    end
    ack = expReq && iRdy;
    if (iRst) begin
      mFetching = 0;
      mFa       = RESET_PC;
      mPc       = RESET_PC;
      mIr       = 16'h0000;
      mValid    = 0;
      mKnown    = 1;
    end else begin
      if (iPcSrc) begin
        mFa    = {iTarget[15:1], 1'b0};
        mValid = 0;
      end else if (ack) begin
        mIr    = mFa ^ KEY;
        mPc    = mFa;
        mValid = 1;
        mFa    = mFa + 16'd2;
      end else if (mValid && !iStall) begin
        mValid = 0;
      end
      mFetching = iEn;
    end
    @(posedge clk);
    #1;
    checkOutput("pc", pc, mPc);
    checkOutput("pcPlus2", pcPlus2, mPc + 16'd2);
    checkOutput("ir", ir, mIr);
    checkOutput("irValid", {15'd0, irValid}, {15'd0, mValid});
    checkOutput("memAddr", memIf.memAddr, mFa);
  endtask

  initial begin
    rst = 1; en = 0; stall = 0; pcSrc = 0; target = 16'h0000;
    memIf.memRdy = 0; memIf.memData = 16'h0000;

    // Reset and straight-line fetch, one instruction per cycle.
    applyStimulus(1, 0, 0, 0, 16'h0, 1);
    applyStimulus(1, 0, 0, 0, 16'h0, 1);
    checkOutput("resetReq", {15'd0, memIf.memReq}, 16'd0);
    checkOutput("resetPcPlus2", pcPlus2, 16'h0002);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 16'h0, 1);
    checkOutput("seqIr", ir, 16'h0008 ^ KEY);

    // Stall hold with PC=4 buffered.
    applyStimulus(1, 0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 16'h0, 1);
    checkOutput("stallPc", pc, 16'h0004);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 16'h0, 1);
    checkOutput("stallHoldIr", ir, 16'hA5A1);
    applyStimulus(0, 1, 0, 0, 16'h0, 1);
    checkOutput("afterStallPc", pc, 16'h0006);

    // Slow memory: four wait cycles per request.
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++) applyStimulus(0, 1, 0, 0, 16'h0, 0);
      applyStimulus(0, 1, 0, 0, 16'h0, 1);
    end

    // Redirect coinciding with an ack; odd target gets aligned.
    applyStimulus(0, 1, 0, 1, 16'h1235, 1);
    checkOutput("redirAddr", memIf.memAddr, 16'h1234);
    checkOutput("redirValid", {15'd0, irValid}, 16'd0);
    applyStimulus(0, 1, 0, 0, 16'h0, 1);
    checkOutput("redirPc", pc, 16'h1234);

    // Wrap around the top of the address space.
    applyStimulus(0, 1, 0, 1, 16'hFFFE, 1);
    applyStimulus(0, 1, 0, 0, 16'h0, 1);
    checkOutput("wrapPc", pc, 16'hFFFE);
    checkOutput("wrapPcPlus2", pcPlus2, 16'h0000);
    applyStimulus(0, 1, 0, 0, 16'h0, 1);
    checkOutput("wrapPcNext", pc, 16'h0000);

    // Reset while a request is pending and IR is valid, then restart.
    applyStimulus(0, 1, 1, 0, 16'h0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 1);
    checkOutput("midResetPc", pc, RESET_PC);
    checkOutput("midResetValid", {15'd0, irValid}, 16'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 16'h0, 1);

    // Randomised traffic with biased controls.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 85,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 8,
                    16'($urandom),
                    $urandom_range(0, 99) < 60);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the 16-bit datapath. Holds the fetch address, issues word requests to instruction memory over a req/ready handshake, and buffers one fetched instruction with its PC for decode. It consumes the 16-bit next-PC target produced by the branch/jump select mux (m16b2_1) on a redirect; otherwise it advances sequentially by INC.

## Interface
- RESET_PC, 16'h0000, fetch address loaded on reset
- INC, 2, sequential address increment in bytes

- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- En  in  1  fetch enable; 0 stops issuing new requests
- Stall  in  1  decode not ready; IR must hold while IRValid=1 and Stall=1
- PCSrc  in  1  redirect request; 1 loads Target as the next fetch address
- Target  in  16  redirect address (mux output); bit 0 ignored
- MemRdy  in  1  memory completes the request this cycle; meaningful only while MemReq=1
- MemData  in  16  instruction word, valid when MemReq=1 and MemRdy=1
- MemReq  out  1  fetch request
- MemAddr  out  16  fetch address (= FA register)
- PC  out  16  address of the instruction in IR
- PCPlus2  out  16  PC + 2, mod 2^16 (link value)
- IR  out  16  buffered instruction
- IRValid  out  1  IR holds an unconsumed instruction

## Operation
- Internal state: FA (16-bit fetch address), state ∈ {IDLE, FETCH}, IRValid flag.
- IDLE: MemReq=0. Next state is FETCH when En=1.
- FETCH: MemReq = !PCSrc && (!IRValid || !Stall). Next state is IDLE when En=0 (an ack in that same cycle is still captured).
- Capture (MemReq && MemRdy): IR<=MemData, PC<=FA, IRValid<=1, FA<=FA+INC.
- Consume: IRValid && !Stall with no capture -> IRValid<=0.
- Redirect (PCSrc=1, any state): FA<={Target[15:1],1'b0}, IRValid<=0, IR/PC keep their old values, MemReq=0 that cycle. The state follows the En rules.
- Priority: RST > PCSrc > capture > consume.
- Arithmetic: FA and PCPlus2 wrap modulo 2^16 (16'hFFFE+2 -> 16'h0000). FA bit 0 is always 0.
- MemAddr is FA directly. It is stable while MemReq is held waiting for MemRdy.

## Timing
- Reset values (cycle after RST=1): state=IDLE, FA=RESET_PC, PC=RESET_PC, IR=16'h0000, IRValid=0, MemReq=0, MemAddr=RESET_PC, PCPlus2=RESET_PC+2.
- RST mid-transaction drops the pending request. No capture occurs in the RST cycle.
- IDLE->FETCH takes 1 cycle, so the first MemReq comes one cycle after En rises.
- Fetch latency: ack in cycle N -> IR/PC/IRValid are updated at N+1. With MemRdy tied high and Stall=0, there is one instruction per cycle.
- Stall: while IRValid=1 and Stall=1, IR, PC, IRValid and FA hold and MemReq=0.
- Redirect in cycle N: no transaction completes in N. IRValid=0 at N+1, and MemAddr=Target at N+1. The first target instruction is valid at N+2 at the earliest.
- MemReq depends combinationally on PCSrc and Stall. All other outputs are registered or derived from registers.

## Test plan
- Reset/sequential: RST for 2 cycles, En=1, MemRdy=1, Stall=0, memory returns addr^16'hA5A5 -> MemReq one cycle after En. IR sequence is 16'hA5A5,16'hA5A7,16'hA5A1… with PC 0,2,4…, one per cycle. PCPlus2 = PC+2.
- Stall hold: IR valid with PC=16'h0004, Stall=1 for 3 cycles -> MemReq=0, IR/PC/FA are unchanged. When Stall drops, the next IR has PC=16'h0006.
- Slow memory: MemRdy low for 4 cycles per request -> MemAddr is stable, IRValid drops after consumption and rises one cycle after each ack.
- Redirect: PCSrc=1, Target=16'h1235, coinciding with MemRdy=1 -> the returned word is discarded, IRValid=0 next cycle, and the next MemAddr is 16'h1234. The first IR afterwards has PC=16'h1234.
- Wrap: PCSrc to 16'hFFFE, then run -> PC sequence 16'hFFFE, 16'h0000, and PCPlus2 at PC=16'hFFFE is 16'h0000.
- Reset mid-operation: RST asserted while MemReq=1 and IRValid=1 -> next cycle all outputs are at reset values. En=1 restarts fetch from RESET_PC.
